zion_riscv_isa_lib_sft_iter_exec: RTL

ZION_RISCV_ISA_LIB_SFT_ITER_EXEC -- requirements
Module: zion_riscv_isa_lib_sft_iter_exec

---
 rtl/zion_riscv_isa_lib_sft_iter_exec.sv | 134 +++++++++++++
 1 files changed

// File: rtl/zion_riscv_isa_lib_sft_iter_exec.sv
// rtl/zion_riscv_isa_lib_sft_iter_exec.sv - iterative shifter/rotator consuming STEP_W amount bits per cycle
module zion_riscv_isa_lib_sft_iter_exec #(
    parameter  int RV64   = 0,
    parameter  int STEP_W = 2,
    localparam int XLEN   = (RV64 != 0) ? 64 : 32,
    localparam int SW     = (RV64 != 0) ? 6 : 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iVld,
    output logic            oRdy,
    input  logic [2:0]      iOp,
    input  logic            iW,
    input  logic [XLEN-1:0] iS1,
    input  logic [SW-1:0]   iS2,
    output logic            oVld,
    input  logic            iRdy,
    output logic [XLEN-1:0] oRslt,
    output logic            oBusy
);

    localparam int ND = (SW + STEP_W - 1) / STEP_W;
    localparam int KW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [SW-1:0] DIG_MASK   = SW'((1 << STEP_W) - 1);
    localparam logic [SW-1:0] W_AMT_MASK = SW'(31);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [2:0]      opR;
    logic            wR;
    logic [XLEN-1:0] acc;
    logic [SW-1:0]   amt;
    logic [KW-1:0]   kCnt;
    logic [XLEN-1:0] rsltR;
    logic            vldR;
    logic            busyR;

    int              shBase;
    logic [SW-1:0]   stepAmt;
    logic            lastDigit;
    logic [XLEN-1:0] nextAcc;
    logic [XLEN-1:0] finalRslt;
    logic            wIn;
    logic            accept;

    function automatic logic [XLEN-1:0] shX(input logic [XLEN-1:0] x, input logic [2:0] op,
                                            input logic [SW-1:0] s);
        case (op)
            3'd0:    return x << s;
            3'd1:    return x >> s;
            3'd2:    return $signed(x) >>> s;
            3'd3:    return (x << s) | (x >> (XLEN - int'(s)));
            3'd4:    return (x >> s) | (x << (XLEN - int'(s)));
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] sh32(input logic [31:0] x, input logic [2:0] op,
                                         input logic [4:0] s);
        case (op)
            3'd0:    return x << s;
            3'd1:    return x >> s;
            3'd2:    return $signed(x) >>> s;
            3'd3:    return (x << s) | (x >> (32 - int'(s)));
            3'd4:    return (x >> s) | (x << (32 - int'(s)));
            default: return '0;
        endcase
    endfunction

    assign wIn    = (RV64 != 0) & iW;
    assign oRdy   = (state == IDLE) | ((state == DONE) & iRdy);
    assign accept = iVld & oRdy;
    assign oVld   = vldR;
    assign oRslt  = rsltR;
    assign oBusy  = busyR;

    // Successive partial shifts compose exactly, so each cycle applies only the current digit's weight.
    always_comb begin
        shBase    = int'(kCnt) * STEP_W;
        stepAmt   = amt & (DIG_MASK << shBase);
        lastDigit = ((amt >> (shBase + STEP_W)) == '0);
        if (wR) nextAcc = XLEN'(sh32(acc[31:0], opR, stepAmt[4:0]));
        else    nextAcc = shX(acc, opR, stepAmt);
        finalRslt = wR ? XLEN'($signed(nextAcc[31:0])) : nextAcc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opR   <= '0;
            wR    <= 1'b0;
            acc   <= '0;
            amt   <= '0;
            kCnt  <= '0;
            rsltR <= '0;
            vldR  <= 1'b0;
            busyR <= 1'b0;
        end else if (accept) begin
            state <= BUSY;
            opR   <= iOp;
            wR    <= wIn;
            acc   <= iS1;
            amt   <= wIn ? (iS2 & W_AMT_MASK) : iS2;
            kCnt  <= '0;
            rsltR <= '0;
            vldR  <= 1'b0;
            busyR <= 1'b1;
        end else begin
            case (state)
                BUSY: begin
                    acc <= nextAcc;
                    if (lastDigit) begin
                        state <= DONE;
                        vldR  <= 1'b1;
                        rsltR <= finalRslt;
                    end else begin
                        kCnt <= kCnt + 1'b1;
                    end
                end
                DONE: begin
                    if (iRdy) begin
                        state <= IDLE;
                        vldR  <= 1'b0;
                        rsltR <= '0;
                        busyR <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
